mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences the single unified RAM port between the instruction-fetch requester (icache side) and the data-memory requester (dcache side) of the pipelined datapath.
- Registered grant FSM. Data requests have priority; a bounded-streak counter guarantees fetch progress.
- Produces the iwait/dwait qualifiers from which the datapath derives dpif_ihit/dpif_dhit for the hazard unit.
- Sits between the datapath-side caches and the RAM model.

Parameters:
- MAX_DSTREAK, 4: max consecutive data grants while iREN is pending before the next grant is forced to instruction.
- CNT_W, 3: width of the streak counter; must satisfy 2^CNT_W > MAX_DSTREAK.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- iREN  input  1  instruction read request.
- iaddr  input  32  instruction word address.
- dREN  input  1  data read request.
- dWEN  input  1  data write request.
- daddr  input  32  data address.
- dstore  input  32  data write value.
- ramstate  input  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR.
- ramload  input  32  RAM read data.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  32  RAM address.
- ramstore  output  32  RAM write data.
- iwait  output  1  high while the instruction request is not complete.
- dwait  output  1  high while the data request is not complete.
- iload  output  32  instruction read data.
- dload  output  32  data read data.

Behaviour:
- Reset (async on nRST low): state=IDLE, streak=0.
  - ramREN, ramWEN = 0; ramaddr, ramstore = 0.
  - iwait, dwait = 1; iload, dload = 0.
- States: IDLE, IGRANT, DGRANT (arb_state_t).
- IDLE:
  - All ram* enables are 0; both waits are 1.
  - Next state: DGRANT if (dREN|dWEN) and not (iREN and streak==MAX_DSTREAK); otherwise IGRANT if iREN; otherwise IDLE.
- IGRANT:
  - ramREN=1, ramaddr=iaddr, ramWEN=0.
  - iwait = (ramstate!=ACCESS); iload=ramload while in this state, otherwise 0.
  - dwait=1.
- DGRANT:
  - ramWEN=dWEN, ramREN=dREN & ~dWEN (write wins if both are asserted; both asserted is illegal but defined).
  - ramaddr=daddr, ramstore=dstore.
  - dwait=(ramstate!=ACCESS); dload=ramload.
  - iwait=1.
- Completion:
  - ramstate==ACCESS in a grant state ends the transfer; next state is IDLE.
  - Each transfer therefore costs one IDLE arbitration cycle plus the RAM latency.
  - The wait-low pulse lasts exactly one cycle. Requesters sample on that edge.
- Withdrawal:
  - If the granted requester drops its enable(s) before ACCESS, the ram* enables fall combinationally.
  - Next state is IDLE and no completion is signalled.
- ERROR: wait stays high; next state is IDLE and the request is re-arbitrated (retry).
- BUSY/FREE in a grant state: hold the state and keep driving the RAM signals.
- Streak counter:
  - On each DGRANT completion with iREN high: streak = streak+1, saturating at MAX_DSTREAK.
  - On each IGRANT completion: streak=0.
  - On a DGRANT completion with iREN low: streak=0.
- ramaddr/ramstore are 0 in IDLE (no stale address driven).
- Reset mid-transfer: immediate return to IDLE with the reset output values. The RAM sees its enables drop asynchronously.

Decomposition:
- aww_types_pkg: arb_state_t enum (IDLE, IGRANT, DGRANT) and the MAX_DSTREAK default constant.
- cpu_types_pkg: ramstate_t and word_t (existing).
- mem_arbiter_if interface:
  - Modport arb: requester signals and ramstate/ramload as inputs; ram* and wait/load signals as outputs.
  - Modport tb: the mirror of arb.
- No sub-module is needed. The streak counter is a few lines within the block.

Test Plan:
- Reset with iREN=1, dREN=1 held → all outputs at reset values; the first cycle after nRST rises is IDLE, followed by DGRANT (ramaddr=daddr).
- Lone iREN, iaddr=0x0000_0040, RAM gives BUSY ×2 then ACCESS with ramload=0x2402_0005 → IGRANT for 3 cycles; iwait low for exactly one cycle with iload=0x2402_0005; then IDLE.
- dWEN=1, daddr=0x0000_0100, dstore=0xDEAD_BEEF concurrent with iREN → DGRANT first with ramWEN=1, ramstore=0xDEAD_BEEF; IGRANT follows after completion.
- dREN held continuously and iREN held, MAX_DSTREAK=4 → exactly 4 data completions, then one IGRANT completion, then streak returns to 0 and data resumes.
- dREN dropped after one BUSY cycle in DGRANT → ramREN falls the same cycle; dwait never goes low; next state is IDLE.
- ramstate=ERROR during IGRANT → iwait stays 1; IDLE, then IGRANT is re-issued at the same iaddr.

Source files
------------

// File: rtl/aww_types_pkg.sv
// Types local to the memory arbiter.
//   arb_state_t         : grant FSM states
//   MAX_DSTREAK_DEFAULT : consecutive data grants allowed while a fetch waits
package aww_types_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    localparam int MAX_DSTREAK_DEFAULT = 4;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types used by the memory subsystem.
//   word_t     : 32-bit machine word
//   ramstate_t : status reported by the RAM model each cycle
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the datapath caches, the arbiter and the RAM model.
//   arb : the arbiter's view (requests and RAM status in, RAM controls and
//         wait/load qualifiers out)
//   tb  : the mirror view, for whatever plays caches and RAM
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    ramstate_t ramstate;
    word_t     ramload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    logic      iwait;
    logic      dwait;
    word_t     iload;
    word_t     dload;

    modport arb (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbiter for the single unified RAM port shared by instruction fetch and
// data access. Data wins contention, but after MAX_DSTREAK data completions
// with a fetch waiting, the next grant goes to the fetch.
//
// Ports:
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   iREN, iaddr        instruction read request and word address
//   dREN, dWEN         data read / write request (write wins if both)
//   daddr, dstore      data address and write value
//   ramstate, ramload  RAM status and read data
//   ramREN, ramWEN     RAM enables (combinational, drop with the request)
//   ramaddr, ramstore  RAM address and write data (zero when idle)
//   iwait, dwait       low for exactly the completing cycle of each side
//   iload, dload       read data, valid while the side's wait is low
module mem_arbiter
    import cpu_types_pkg::*;
    import aww_types_pkg::*;
#(
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEFAULT,
    parameter int CNT_W       = 3
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  ramstate_t ramstate,
    input  word_t     ramload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload
);

    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DSTREAK);

    arb_state_t       state, next_state;
    logic [CNT_W-1:0] streak, next_streak;
    logic             d_req;
    logic             i_forced;

    assign d_req    = dREN | dWEN;
    // A waiting fetch that has already sat through a full data streak
    // takes the next grant even if data is also asking.
    assign i_forced = iREN && (streak == STREAK_MAX);

    // State and streak registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= next_state;
            streak <= next_streak;
        end
    end

    // Arbitration, RAM drive and completion. Every grant ends in IDLE,
    // whether it completed, errored (retry via re-arbitration) or was
    // withdrawn by the requester.
    always_comb begin
        next_state  = state;
        next_streak = streak;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = 1'b1;
        dwait       = 1'b1;
        iload       = '0;
        dload       = '0;

        unique case (state)
            IDLE: begin
                if (d_req && !i_forced) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end

            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (ramstate == ACCESS) begin
                    iwait       = 1'b0;
                    next_state  = IDLE;
                    next_streak = '0;
                end else if (ramstate == ERROR) begin
                    next_state = IDLE;
                end
            end

            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                if (!d_req) begin
                    next_state = IDLE;
                end else if (ramstate == ACCESS) begin
                    dwait      = 1'b0;
                    next_state = IDLE;
                    // The streak only measures data wins over a waiting fetch.
                    if (!iREN) begin
                        next_streak = '0;
                    end else if (streak != STREAK_MAX) begin
                        next_streak = streak + 1'b1;
                    end
                end else if (ramstate == ERROR) begin
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Requesters push the response they
// expect into per-side queues; a monitor pops and compares whenever a wait
// line drops. A behavioural RAM answers with random latency and errors, and
// a shadow memory gives the expected read data.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int MAX_DSTREAK = 4;
    localparam int CYCLE_LIMIT = 400;

    typedef struct packed {
        logic  is_write;
        word_t data;
    } dexp_t;

    logic CLK = 1'b0;
    logic nRST;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_DSTREAK(MAX_DSTREAK), .CNT_W(3)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (bus.iREN),
        .iaddr    (bus.iaddr),
        .dREN     (bus.dREN),
        .dWEN     (bus.dWEN),
        .daddr    (bus.daddr),
        .dstore   (bus.dstore),
        .ramstate (bus.ramstate),
        .ramload  (bus.ramload),
        .ramREN   (bus.ramREN),
        .ramWEN   (bus.ramWEN),
        .ramaddr  (bus.ramaddr),
        .ramstore (bus.ramstore),
        .iwait    (bus.iwait),
        .dwait    (bus.dwait),
        .iload    (bus.iload),
        .dload    (bus.dload)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          failures = 0;
    word_t       iq[$];
    dexp_t       dq[$];
    logic [7:0]  order_log[$];
    ramstate_t   forced[$];
    bit          err_enable = 1'b0;
    word_t       ram_mem[int unsigned];
    word_t       shadow[int unsigned];
    int          streak_m = 0;

    bit          i_pending = 1'b0;
    bit          d_pending = 1'b0;
    logic        d_wr_cur;
    word_t       d_addr_cur;
    word_t       d_data_cur;

    function automatic word_t init_word(input word_t addr);
        return (addr * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic word_t ram_read(input word_t addr);
        if (ram_mem.exists(addr)) return ram_mem[addr];
        return init_word(addr);
    endfunction

    function automatic word_t shadow_read(input word_t addr);
        if (shadow.exists(addr)) return shadow[addr];
        return init_word(addr);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic check_true(input string name, input bit cond);
        checks++;
        if (!cond) begin
            failures++;
            $display("[TB] FAIL %s: condition false, required true", name);
        end
    endtask

    // Requester side: drive a request and record what it should return.
    task automatic issue_i(input word_t addr);
        bus.iREN  = 1'b1;
        bus.iaddr = addr;
        iq.push_back(shadow_read(addr));
        i_pending = 1'b1;
    endtask

    task automatic issue_d(input logic wr, input word_t addr, input word_t data);
        dexp_t e;
        bus.dWEN   = wr;
        bus.dREN   = !wr;
        bus.daddr  = addr;
        bus.dstore = data;
        e.is_write = wr;
        e.data     = wr ? 32'h0 : shadow_read(addr);
        dq.push_back(e);
        d_pending  = 1'b1;
        d_wr_cur   = wr;
        d_addr_cur = addr;
        d_data_cur = data;
    endtask

    task automatic drop_i();
        if (i_pending) void'(iq.pop_back());
        i_pending = 1'b0;
        bus.iREN  = 1'b0;
    endtask

    task automatic drop_d();
        if (d_pending) void'(dq.pop_back());
        d_pending = 1'b0;
        bus.dREN  = 1'b0;
        bus.dWEN  = 1'b0;
    endtask

    // One cycle as the caches see it: sample at negedge, react after posedge.
    task automatic step(output bit ic, output bit dc);
        @(negedge CLK);
        ic = i_pending && !bus.iwait;
        dc = d_pending && !bus.dwait;
        @(posedge CLK);
        #1;
        if (ic) begin
            i_pending = 1'b0;
            bus.iREN  = 1'b0;
        end
        if (dc) begin
            if (d_wr_cur) shadow[d_addr_cur] = d_data_cur;
            d_pending = 1'b0;
            bus.dREN  = 1'b0;
            bus.dWEN  = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        bit ic, dc;
        while ((i_pending || d_pending) && cyc < CYCLE_LIMIT) begin
            step(ic, dc);
            cyc++;
        end
        check_true({name, " completes in time"}, !(i_pending || d_pending));
        drop_i();
        drop_d();
    endtask

    // Behavioural RAM: random BUSY latency, optional ERROR, or a forced script.
    initial begin : ram_model
        int busy_left;
        bit active;
        busy_left = 0;
        active = 1'b0;
        bus.ramstate = FREE;
        bus.ramload = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (bus.ramREN || bus.ramWEN) begin
                if (!active) begin
                    active = 1'b1;
                    busy_left = $urandom_range(0, 2);
                end
                if (forced.size() > 0) bus.ramstate = forced.pop_front();
                else if (busy_left > 0) begin
                    bus.ramstate = BUSY;
                    busy_left--;
                end else if (err_enable && $urandom_range(0, 7) == 0) bus.ramstate = ERROR;
                else bus.ramstate = ACCESS;
                if (bus.ramstate == ACCESS && bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
                bus.ramload = (bus.ramstate == ACCESS && bus.ramREN) ? ram_read(bus.ramaddr)
                                                                     : word_t'($urandom);
                if (bus.ramstate == ACCESS || bus.ramstate == ERROR) active = 1'b0;
            end else begin
                active = 1'b0;
                bus.ramstate = FREE;
                bus.ramload = word_t'($urandom);
            end
        end
    end

    // Monitor / scoreboard: every completion must match the oldest expected
    // response of its side, and no more than MAX_DSTREAK data completions may
    // happen back to back while a fetch is waiting.
    initial begin : monitor
        bit    prev_i_low = 1'b0;
        bit    prev_d_low = 1'b0;
        word_t iexp;
        dexp_t dexp;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                streak_m = 0;
                prev_i_low = 1'b0;
                prev_d_low = 1'b0;
            end else begin
                if (!bus.iwait || !bus.dwait) check_true("single completion", bus.iwait || bus.dwait);
                if (!bus.iwait) begin
                    check_true("iwait one-cycle pulse", !prev_i_low);
                    check_true("expected fetch outstanding", iq.size() > 0);
                    if (iq.size() > 0) begin
                        iexp = iq.pop_front();
                        check_output("iload", bus.iload, iexp);
                    end
                    streak_m = 0;
                    order_log.push_back("I");
                end
                if (!bus.dwait) begin
                    check_true("dwait one-cycle pulse", !prev_d_low);
                    check_true("expected data outstanding", dq.size() > 0);
                    if (dq.size() > 0) begin
                        dexp = dq.pop_front();
                        check_output("ramWEN at data completion", {31'b0, bus.ramWEN},
                                     {31'b0, dexp.is_write});
                        if (!dexp.is_write) check_output("dload", bus.dload, dexp.data);
                    end
                    if (bus.iREN) begin
                        check_true("fetch not starved by data streak", streak_m < MAX_DSTREAK);
                        if (streak_m < MAX_DSTREAK) streak_m++;
                    end else begin
                        streak_m = 0;
                    end
                    order_log.push_back("D");
                end
                prev_i_low = !bus.iwait;
                prev_d_low = !bus.dwait;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int    base;
        int    grant_cycles;
        bit    done;
        bit    ic, dc;
        int    n;
        int    cyc;
        int    d_gap;
        string exp_order;

        nRST = 1'b0;
        bus.iREN = 1'b0;
        bus.iaddr = '0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        bus.daddr = '0;
        bus.dstore = '0;

        // Reset with both requests held; data gets the first grant.
        @(posedge CLK);
        #1;
        issue_i(32'h0000_0044);
        issue_d(1'b0, 32'h0000_0100, 32'h0);
        forced.push_back(BUSY);
        repeat (2) @(negedge CLK);
        check_output("reset ramREN", {31'b0, bus.ramREN}, 32'h0);
        check_output("reset ramWEN", {31'b0, bus.ramWEN}, 32'h0);
        check_output("reset ramaddr", bus.ramaddr, 32'h0);
        check_output("reset ramstore", bus.ramstore, 32'h0);
        check_output("reset iwait", {31'b0, bus.iwait}, 32'h1);
        check_output("reset dwait", {31'b0, bus.dwait}, 32'h1);
        check_output("reset iload", bus.iload, 32'h0);
        check_output("reset dload", bus.dload, 32'h0);
        nRST = 1'b1;
        #1;
        check_output("idle after reset ramREN", {31'b0, bus.ramREN}, 32'h0);
        @(negedge CLK);
        check_output("first grant ramREN", {31'b0, bus.ramREN}, 32'h1);
        check_output("first grant ramaddr", bus.ramaddr, 32'h0000_0100);
        wait_idle("reset pair");

        // Lone fetch with a scripted two-cycle RAM latency.
        ram_mem[32'h0000_0040] = 32'h2402_0005;
        shadow[32'h0000_0040] = 32'h2402_0005;
        @(posedge CLK);
        #1;
        forced.push_back(BUSY);
        forced.push_back(BUSY);
        forced.push_back(ACCESS);
        issue_i(32'h0000_0040);
        grant_cycles = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge CLK);
            if (bus.ramREN && !bus.ramWEN && bus.ramaddr == 32'h0000_0040) grant_cycles++;
            if (!bus.iwait) done = 1'b1;
        end
        check_output("igrant cycles", grant_cycles, 32'd3);
        check_true("lone fetch completes", done);
        @(posedge CLK);
        #1;
        if (done) begin
            i_pending = 1'b0;
            bus.iREN = 1'b0;
        end else drop_i();
        @(negedge CLK);
        check_output("idle after fetch ramREN", {31'b0, bus.ramREN}, 32'h0);
        check_output("idle after fetch iwait", {31'b0, bus.iwait}, 32'h1);

        // Write concurrent with a fetch: write first, then the fetch.
        base = order_log.size();
        @(posedge CLK);
        #1;
        forced.push_back(BUSY);
        issue_d(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        issue_i(32'h0000_0044);
        @(negedge CLK);
        @(negedge CLK);
        check_output("write grant ramWEN", {31'b0, bus.ramWEN}, 32'h1);
        check_output("write grant ramREN", {31'b0, bus.ramREN}, 32'h0);
        check_output("write grant ramstore", bus.ramstore, 32'hDEAD_BEEF);
        check_output("write grant ramaddr", bus.ramaddr, 32'h0000_0100);
        wait_idle("write then fetch");
        check_output("write landed in RAM", ram_read(32'h0000_0100), 32'hDEAD_BEEF);
        exp_order = "DI";
        for (int k = 0; k < 2; k++)
            check_output($sformatf("write/fetch order %0d", k),
                         (order_log.size() > base + k) ? {24'b0, order_log[base + k]} : 32'h0,
                         {24'b0, exp_order[k]});

        // Continuous data and fetch traffic: four data wins, then the fetch.
        base = order_log.size();
        @(posedge CLK);
        #1;
        issue_d(1'b0, 32'h0000_0104, 32'h0);
        issue_i(32'h0000_0048);
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < CYCLE_LIMIT) begin
            step(ic, dc);
            cyc++;
            if (ic) n++;
            if (dc) n++;
            if (n < 6) begin
                if (ic) issue_i(32'h0000_0048 + word_t'(4 * n));
                if (dc) issue_d(1'b0, 32'h0000_0104 + word_t'(4 * n), 32'h0);
            end
        end
        check_true("streak traffic completes in time", n == 6);
        drop_i();
        drop_d();
        exp_order = "DDDDID";
        for (int k = 0; k < 6; k++)
            check_output($sformatf("streak order %0d", k),
                         (order_log.size() > base + k) ? {24'b0, order_log[base + k]} : 32'h0,
                         {24'b0, exp_order[k]});

        // Data read withdrawn after one BUSY cycle.
        @(posedge CLK);
        #1;
        forced.push_back(BUSY);
        issue_d(1'b0, 32'h0000_0108, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        check_output("pre-withdraw ramREN", {31'b0, bus.ramREN}, 32'h1);
        @(posedge CLK);
        #1;
        drop_d();
        #1;
        check_output("withdraw ramREN falls", {31'b0, bus.ramREN}, 32'h0);
        @(negedge CLK);
        check_output("withdraw dwait", {31'b0, bus.dwait}, 32'h1);
        @(negedge CLK);
        check_output("withdraw then idle ramaddr", bus.ramaddr, 32'h0);

        // RAM error during a fetch: retry at the same address.
        @(posedge CLK);
        #1;
        forced.push_back(ERROR);
        forced.push_back(ACCESS);
        issue_i(32'h0000_004C);
        @(negedge CLK);
        @(negedge CLK);
        check_output("error iwait", {31'b0, bus.iwait}, 32'h1);
        check_output("error ramaddr", bus.ramaddr, 32'h0000_004C);
        @(negedge CLK);
        check_output("after error idle ramREN", {31'b0, bus.ramREN}, 32'h0);
        @(negedge CLK);
        check_output("retry ramREN", {31'b0, bus.ramREN}, 32'h1);
        check_output("retry ramaddr", bus.ramaddr, 32'h0000_004C);
        check_output("retry iwait", {31'b0, bus.iwait}, 32'h0);
        done = !bus.iwait;
        @(posedge CLK);
        #1;
        if (done) begin
            i_pending = 1'b0;
            bus.iREN = 1'b0;
        end else drop_i();

        // Reset in the middle of a write grant.
        @(posedge CLK);
        #1;
        forced.push_back(BUSY);
        forced.push_back(BUSY);
        forced.push_back(BUSY);
        issue_d(1'b1, 32'h0000_010C, 32'h1234_5678);
        issue_i(32'h0000_0050);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        check_output("async reset ramWEN", {31'b0, bus.ramWEN}, 32'h0);
        check_output("async reset ramaddr", bus.ramaddr, 32'h0);
        check_output("async reset ramstore", bus.ramstore, 32'h0);
        check_output("async reset dwait", {31'b0, bus.dwait}, 32'h1);
        drop_d();
        drop_i();
        forced.delete();
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Random traffic: fetch always pending, data with gaps, writes, errors.
        err_enable = 1'b1;
        @(posedge CLK);
        #1;
        issue_i(word_t'(4 * $urandom_range(0, 63)));
        d_gap = 0;
        n = 0;
        cyc = 0;
        while (n < 80 && cyc < 4000) begin
            if (!d_pending) begin
                if (d_gap > 0) d_gap--;
                else if ($urandom_range(0, 2) == 0)
                    issue_d(1'b1, 32'h0000_0100 + word_t'(4 * $urandom_range(0, 63)),
                            word_t'($urandom));
                else
                    issue_d(1'b0, 32'h0000_0100 + word_t'(4 * $urandom_range(0, 63)), 32'h0);
            end
            step(ic, dc);
            cyc++;
            if (ic) begin
                n++;
                issue_i(word_t'(4 * $urandom_range(0, 63)));
            end
            if (dc) begin
                n++;
                d_gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end
        end
        check_true("random traffic completes in time", n >= 80);
        drop_i();
        drop_d();
        err_enable = 1'b0;
        repeat (3) @(negedge CLK);
        check_output("fetch scoreboard drained", iq.size(), 32'h0);
        check_output("data scoreboard drained", dq.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
